// File: rtl/mem_arb_pkg.sv
// Shared types and memop encodings for the data_mem arbiter and other data_mem users.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   // funct3 encodings as seen by data_mem
   localparam logic [2:0] MEMOP_LB  = 3'b000;
   localparam logic [2:0] MEMOP_LH  = 3'b001;
   localparam logic [2:0] MEMOP_LW  = 3'b010;
   localparam logic [2:0] MEMOP_LBU = 3'b100;
   localparam logic [2:0] MEMOP_LHU = 3'b101;
   localparam logic [2:0] MEMOP_SB  = 3'b000;
   localparam logic [2:0] MEMOP_SH  = 3'b001;
   localparam logic [2:0] MEMOP_SW  = 3'b010;

endpackage

// File: rtl/mem_arb_fsm.sv
// Round-robin grant FSM with a bounded burst length per owner.
// Compiled out when MEM_ARB_FIXED_PRIO_EN is defined.
`ifndef MEM_ARB_FIXED_PRIO_EN
module mem_arb_fsm
   import mem_arb_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             last_q, last_d;
   logic             under_limit;

   assign under_limit = (burst_cnt_q < CNT_MAX);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      state_d     = IDLE;
      burst_cnt_d = '0;
      last_d      = last_q;

      case (state_q)
         OWN0: begin
            if (req0 && (under_limit || !req1)) gnt0 = 1'b1;
            else if (req1)                      gnt1 = 1'b1;
         end
         OWN1: begin
            if (req1 && (under_limit || !req0)) gnt1 = 1'b1;
            else if (req0)                      gnt0 = 1'b1;
         end
         default: begin
            if (req0 && req1) begin
               gnt0 = last_q;
               gnt1 = !last_q;
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
         end
      endcase

      // Grants are suppressed while reset is held, regardless of requests.
      if (!rst_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end

      if (gnt0) begin
         state_d     = OWN0;
         last_d      = 1'b0;
         burst_cnt_d = (state_q != OWN0) ? CNT_ONE :
                       (under_limit ? burst_cnt_q + CNT_ONE : burst_cnt_q);
      end else if (gnt1) begin
         state_d     = OWN1;
         last_d      = 1'b1;
         burst_cnt_d = (state_q != OWN1) ? CNT_ONE :
                       (under_limit ? burst_cnt_q + CNT_ONE : burst_cnt_q);
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         last_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
      end
   end

endmodule
`endif

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-ported data_mem, with registered load responses.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 > port 1) instead of round-robin.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int BURST_MAX     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0,
   input  logic                     req1,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [ADDRESS_WIDTH-1:0] addr0,
   input  logic [ADDRESS_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0]    wdata0,
   input  logic [DATA_WIDTH-1:0]    wdata1,
   input  logic [2:0]               memop0,
   input  logic [2:0]               memop1,
   output logic                     gnt0,
   output logic                     gnt1,
   output logic                     rvalid0,
   output logic                     rvalid1,
   output logic [DATA_WIDTH-1:0]    rdata0,
   output logic [DATA_WIDTH-1:0]    rdata1,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic                     mem_we,
   output logic [DATA_WIDTH-1:0]    mem_writedata,
   output logic [2:0]               mem_memop,
   input  logic [DATA_WIDTH-1:0]    mem_readdata
);

   logic                  rvalid0_q, rvalid1_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
   logic                  load0, load1;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign gnt0 = rst_n && req0;
   assign gnt1 = rst_n && req1 && !req0;
`else
   mem_arb_fsm #(
      .BURST_MAX (BURST_MAX)
   ) u_fsm (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );
`endif

   always_comb begin
      mem_a         = '0;
      mem_we        = 1'b0;
      mem_writedata = '0;
      mem_memop     = MEMOP_LW;
      if (gnt0) begin
         mem_a         = addr0;
         mem_we        = we0;
         mem_writedata = wdata0;
         mem_memop     = memop0;
      end else if (gnt1) begin
         mem_a         = addr1;
         mem_we        = we1;
         mem_writedata = wdata1;
         mem_memop     = memop1;
      end
      if (!rst_n) mem_we = 1'b0;
   end

   assign load0 = gnt0 && !we0;
   assign load1 = gnt1 && !we1;

   // NOTE: rdata registers are reset because they are plain output flops, not a memory array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= load0;
         rvalid1_q <= load1;
         if (load0) rdata0_q <= mem_readdata;
         if (load1) rdata1_q <= mem_readdata;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-ported `data_mem` between the core load/store unit (port 0) and a DMA/debug loader (port 1). It grants at most one requester per cycle and drives `data_mem`'s `a`/`we`/`writedata`/`memop`. It registers the asynchronous read result back to the granted reader. Round-robin with a bounded burst length keeps either port from starving the other.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, address width on all ports.
- `DATA_WIDTH`, 32, data width on all ports.
- `BURST_MAX`, 4, maximum consecutive grants to one owner while the other port is requesting (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request per port; held until granted.
- `we0`, `we1`  in  1  1 = store, 0 = load.
- `addr0`, `addr1`  in  ADDRESS_WIDTH  byte address.
- `wdata0`, `wdata1`  in  DATA_WIDTH  store data.
- `memop0`, `memop1`  in  3  funct3 encoding (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `gnt0`, `gnt1`  out  1  combinational grant; the transaction occurs in the cycle where `req & gnt`.
- `rvalid0`, `rvalid1`  out  1  registered; high for one cycle after a granted load.
- `rdata0`, `rdata1`  out  DATA_WIDTH  registered load data, valid with `rvalid`.
- `mem_a`  out  ADDRESS_WIDTH  drives `data_mem` address.
- `mem_we`  out  1  drives `data_mem` write enable.
- `mem_writedata`  out  DATA_WIDTH  drives `data_mem` write data.
- `mem_memop`  out  3  drives `data_mem` memop.
- `mem_readdata`  in  DATA_WIDTH  asynchronous read data from `data_mem`.

## Operation
- FSM states: IDLE, OWN0, OWN1. Additional registers:
  - `burst_cnt`, sized for 0..BURST_MAX.
  - `last`, the port most recently granted.
- Grant selection (combinational):
  - IDLE, one port requesting: grant that port.
  - IDLE, both requesting: grant the port ≠ `last`.
  - OWNx: keep x if `reqx && (burst_cnt < BURST_MAX || !req_other)`.
  - OWNx, keep condition false: grant the other port if it requests, else grant none.
- State update each edge:
  - Granted port p, p same as previous owner: state = OWNp, `burst_cnt` increments and saturates at BURST_MAX.
  - Granted port p, owner switched: state = OWNp, `burst_cnt` = 1.
  - Any grant: `last` = p.
  - No grant: IDLE, `burst_cnt` = 0; `last` unchanged.
- `gnt0 & gnt1` is never 1.
- Memory mux:
  - Granted port's `addr`/`we`/`wdata`/`memop` go to `mem_*`.
  - No grant: `mem_we` = 0, `mem_a` = 0, `mem_memop` = 3'b010.
  - `mem_we` is forced 0 while `rst_n` is low.
- Load response: on a granted load, `mem_readdata` is captured at the edge into `rdata_p`, and `rvalid_p` = 1 for the next cycle only. The other port's `rdata` holds its old value.
- Store: committed by `data_mem` at the grant edge; no response.

## Timing
- Grant latency is 0 cycles (same cycle as `req`) when selected. Load data latency is 1 cycle.
- A port with a pending request waits at most BURST_MAX cycles.
- Back-to-back loads from one port produce `rvalid` on consecutive cycles.
- Reset values:
  - state IDLE, `burst_cnt` 0, `last` 1, so port 0 wins the first tie.
  - `rvalid0` = `rvalid1` = 0; `rdata0` = `rdata1` = 0.
  - `gnt*` and `mem_we` are 0 while in reset.
- Reset mid-burst: state returns to IDLE immediately. A load granted in the cycle reset asserts produces no `rvalid`.
- Request dropped by the owner: ownership is released the same cycle, and the other port may be granted in that cycle.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, port 0 > port 1, every cycle.
  - FSM, `burst_cnt` and `last` are compiled out; port 1 can starve.
  - Response path and mux are unchanged.
- `MEM_ARB_FIXED_PRIO_EN` undefined: round-robin with burst limit, as above.

## Structure
- `mem_arb_pkg`:
  - State enum `arb_state_t` (IDLE, OWN0, OWN1).
  - Memop constants `MEMOP_LB`/`LH`/`LW`/`LBU`/`LHU`, shared with `data_mem` users.
- Sub-module `mem_arb_fsm`:
  - Holds state, `burst_cnt` and `last`.
  - Inputs `req0`/`req1`; outputs `gnt0`/`gnt1`.
  - Excluded under `MEM_ARB_FIXED_PRIO_EN`.
- Top level holds the request mux and the response registers.

## Test plan
- Reset then `req0` load LW at 0x4, memory holding 0xDEADBEEF there: `gnt0` = 1 the same cycle, `rvalid0` = 1 and `rdata0` = 0xDEADBEEF next cycle, `rvalid1` stays 0.
- `req0` and `req1` asserted together from reset: port 0 granted first. If port 0 then drops `req0` while `req1` holds, port 1 is granted the next cycle.
- Both hold `req` continuously with BURST_MAX = 4: grant pattern is 0,0,0,0,1,1,1,1,0… and `gnt0 & gnt1` is never 1.
- Port 1 SB 0xAB at 0x3, then port 0 LBU at 0x3: `rdata0` = 0x000000AB. `mem_we` is high only in port 1's grant cycle.
- `rst_n` pulsed low mid-burst during a port 1 load: `rvalid1` = 0 and `mem_we` = 0 while low; after release, a tie grants port 0.
- With `MEM_ARB_FIXED_PRIO_EN` and both requesting for 10 cycles: `gnt0` = 1 for all 10 and `gnt1` = 0.
